slt_32_bit_unit: RTL and testbench

//   Registered 32-bit set-less-than unit for the MIPS ALU datapath (SLT/SLTU).

---
 rtl/slt_32_bit_unit.sv | 61 ++++++
 tb/tb_slt_32_bit_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/slt_32_bit_unit.sv
// rtl/slt_32_bit_unit.sv - registered set-less-than (SLT/SLTU) built on a ripple-carry subtractor
module slt_fa_slice (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module slt_32_bit_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_unsigned,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   carry;
    logic             overflow;
    logic             less;
    logic             diff_low_unused;

    // a - b as a + ~b + 1: the +1 enters as the chain's carry-in
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        slt_fa_slice u_slice (
            .x    (a[i]),
            .y    (~b[i]),
            .cin  (carry[i]),
            .s    (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Only the sign bit of the difference feeds the compare
    assign diff_low_unused = ^diff[WIDTH-2:0];

    assign overflow = carry[WIDTH-1] ^ carry[WIDTH];
    assign less     = is_unsigned ? ~carry[WIDTH] : (diff[WIDTH-1] ^ overflow);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            result    <= {{(WIDTH-1){1'b0}}, less};
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_slt_32_bit_unit.sv
// tb/tb_slt_32_bit_unit.sv - scoreboard bench for slt_32_bit_unit
module tb_slt_32_bit_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        is_unsigned = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [31:0] result;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;
    logic        mon_en = 1'b0;

    slt_32_bit_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .is_unsigned (is_unsigned),
        .out_valid   (out_valid),
        .result      (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_slt(input logic [31:0] x, input logic [31:0] y,
                                            input logic u);
        logic lt;
        if (u) lt = (x < y);
        else   lt = ($signed(x) < $signed(y));
        return {31'b0, lt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic u,
                         input logic v);
        @(negedge clk);
        in_valid    = v;
        a           = x;
        b           = y;
        is_unsigned = u;
        if (v) begin
            last_exp = ref_slt(x, y, u);
            exp_q.push_back(last_exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, out_valid must match whether a compare was captured
    initial begin
        logic [31:0] e;
        logic        exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                exp_v = (exp_q.size() != 0);
                check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
                check("result_upper_zero", {1'b0, result[31:1]}, 32'h0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (out_valid === 1'b1) check("result", result, e);
                end
            end
        end
    end

    logic [31:0] sa[13];
    logic [31:0] sb[13];
    logic        su[13];
    logic [31:0] corner[8];

    initial begin
        sa = '{32'd0, 32'hFFFFFFF9, 32'd8, 32'd128, 32'd6,
               32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF,
               32'hFFFFFFF9, 32'd6, 32'h80000000, 32'd5, 32'hFFFFFFFF};
        sb = '{32'd0, 32'd6, 32'd48, 32'd64, 32'd7,
               32'd1, 32'hFFFFFFFF, 32'h80000000,
               32'd6, 32'hFFFFFFF9, 32'd1, 32'd5, 32'hFFFFFFFF};
        su = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                   32'h80000000, 32'h80000001, 32'hFFFFFFFE, 32'h7FFFFFFE};

        // Reset for two edges
        rst_n = 1'b0;
        sample();
        sample();
        check("reset_result", result, 32'h0);
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        mon_en = 1'b1;

        @(negedge clk);
        rst_n = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);

        // Directed signed, overflow and unsigned cases back to back
        for (int i = 0; i < 13; i++) drive(sa[i], sb[i], su[i], 1'b1);
        drive('0, '0, 1'b0, 1'b0);

        // Single pulse then idle: result must hold
        drive(32'd6, 32'd7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
            sample();
            check("hold_result", result, last_exp);
        end

        // Reset on the same edge as a valid compare
        drive(32'd6, 32'd7, 1'b0, 1'b1);
        @(negedge clk);
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        a           = 32'hFFFFFFFF;
        b           = 32'h0;
        is_unsigned = 1'b0;
        sample();
        check("midreset_result", result, 32'h0);
        check("midreset_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Random traffic with corner operands mixed in and idle gaps
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 15) == 0) y = x;
            drive(x, y, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        end

        drive('0, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        sample();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
